// File: rtl/ohsm_param_seq.sv
// Parametrised one-hot state sequencer with direction, wrap/saturate, clear and indexed load.
// Optional timed auto-stepping is built when OHSM_AUTOSTEP_EN is defined.
module ohsm_param_seq #(
    parameter int unsigned NUM_STATES = 4,
    parameter int unsigned WRAP       = 1,
    parameter int unsigned DWELL      = 8,
    localparam int unsigned IDX_W     = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1
) (
    input  logic                  clk,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic                  dir_i,
    input  logic                  clear_i,
    input  logic                  load_i,
    input  logic [IDX_W-1:0]      load_idx_i,
    input  logic                  auto_en_i,
    output logic [NUM_STATES-1:0] state_oh_o,
    output logic [IDX_W-1:0]      state_idx_o,
    output logic                  at_first_o,
    output logic                  at_last_o,
    output logic                  step_pulse_o,
    output logic                  load_err_o
);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_STATES - 1);
    localparam logic [IDX_W-1:0] FIRST_IDX = '0;

    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_STATES-1:0] oh_q, oh_d;
    logic                  start_q;
    logic                  step_pulse_q, step_pulse_d;
    logic                  load_err_q, load_err_d;
    logic                  auto_fire_c;
    logic                  step_req_c;

    assign step_req_c = (start_i & ~start_q) | auto_fire_c;

`ifdef OHSM_AUTOSTEP_EN
    localparam int unsigned CNT_W = $clog2(DWELL + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Dwell counter restarts on any index-affecting request so a manual step re-times the next auto step.
    always_comb begin
        auto_fire_c = auto_en_i && (cnt_q == CNT_W'(DWELL - 1));
        cnt_d       = cnt_q + CNT_W'(1);
        if (clear_i || load_i || step_req_c || !auto_en_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_auto_en;

    assign auto_fire_c    = 1'b0;
    assign unused_auto_en = auto_en_i;
`endif

    // Next index: clear > load > step; end handling uses explicit compares, never natural overflow.
    always_comb begin
        idx_d        = idx_q;
        step_pulse_d = 1'b0;
        load_err_d   = 1'b0;
        if (clear_i) begin
            idx_d = FIRST_IDX;
        end else if (load_i) begin
            if (32'(load_idx_i) < NUM_STATES) begin
                idx_d = load_idx_i;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (step_req_c) begin
            if (!dir_i) begin
                if (idx_q != LAST_IDX) begin
                    idx_d        = idx_q + IDX_W'(1);
                    step_pulse_d = 1'b1;
                end else if (WRAP != 0) begin
                    idx_d        = FIRST_IDX;
                    step_pulse_d = 1'b1;
                end
            end else begin
                if (idx_q != FIRST_IDX) begin
                    idx_d        = idx_q - IDX_W'(1);
                    step_pulse_d = 1'b1;
                end else if (WRAP != 0) begin
                    idx_d        = LAST_IDX;
                    step_pulse_d = 1'b1;
                end
            end
        end
    end

    // One-hot is decoded from the next index so both registers always agree.
    always_comb begin
        oh_d = '0;
        for (int unsigned i = 0; i < NUM_STATES; i++) begin
            oh_d[i] = (idx_d == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            idx_q        <= FIRST_IDX;
            oh_q         <= NUM_STATES'(1);
            start_q      <= 1'b1;
            step_pulse_q <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            oh_q         <= oh_d;
            start_q      <= start_i;
            step_pulse_q <= step_pulse_d;
            load_err_q   <= load_err_d;
        end
    end

    assign state_oh_o   = oh_q;
    assign state_idx_o  = idx_q;
    assign at_first_o   = (idx_q == FIRST_IDX);
    assign at_last_o    = (idx_q == LAST_IDX);
    assign step_pulse_o = step_pulse_q;
    assign load_err_o   = load_err_q;

endmodule

// File: tb/tb_ohsm_param_seq.sv
// Directed bench for ohsm_param_seq: a wrapping 4-state, a saturating 4-state and a wrapping 5-state
// instance share one stimulus stream; auto-step checks depend on OHSM_AUTOSTEP_EN.
module tb_ohsm_param_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       dir;
    logic       clear;
    logic       load;
    logic [2:0] load_idx;
    logic       auto_en;

    logic [3:0] w_oh,  s_oh;
    logic [1:0] w_idx, s_idx;
    logic       w_first, w_last, w_pulse, w_err;
    logic       s_first, s_last, s_pulse, s_err;
    logic [4:0] f_oh;
    logic [2:0] f_idx;
    logic       f_first, f_last, f_pulse, f_err;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    ohsm_param_seq #(.NUM_STATES(4), .WRAP(1), .DWELL(3)) dut_w (
        .clk(clk), .reset_i(reset), .start_i(start), .dir_i(dir), .clear_i(clear),
        .load_i(load), .load_idx_i(load_idx[1:0]), .auto_en_i(auto_en),
        .state_oh_o(w_oh), .state_idx_o(w_idx), .at_first_o(w_first), .at_last_o(w_last),
        .step_pulse_o(w_pulse), .load_err_o(w_err));

    ohsm_param_seq #(.NUM_STATES(4), .WRAP(0), .DWELL(3)) dut_s (
        .clk(clk), .reset_i(reset), .start_i(start), .dir_i(dir), .clear_i(clear),
        .load_i(load), .load_idx_i(load_idx[1:0]), .auto_en_i(auto_en),
        .state_oh_o(s_oh), .state_idx_o(s_idx), .at_first_o(s_first), .at_last_o(s_last),
        .step_pulse_o(s_pulse), .load_err_o(s_err));

    ohsm_param_seq #(.NUM_STATES(5), .WRAP(1), .DWELL(3)) dut_f (
        .clk(clk), .reset_i(reset), .start_i(start), .dir_i(dir), .clear_i(clear),
        .load_i(load), .load_idx_i(load_idx), .auto_en_i(auto_en),
        .state_oh_o(f_oh), .state_idx_o(f_idx), .at_first_o(f_first), .at_last_o(f_last),
        .step_pulse_o(f_pulse), .load_err_o(f_err));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_w [4];
        logic [3:0] exp_s [4];
        logic [4:0] exp_f [4];
        logic       exp_sp [4];
        logic [3:0] auto_oh [10];
        logic       auto_p [10];

        exp_w  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_s  = '{4'b0010, 4'b0100, 4'b1000, 4'b1000};
        exp_f  = '{5'b00010, 5'b00100, 5'b01000, 5'b10000};
        exp_sp = '{1'b1, 1'b1, 1'b1, 1'b0};
        auto_oh = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010,
                    4'b0100, 4'b1000, 4'b1000, 4'b1000, 4'b0001};
        auto_p  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

        reset = 1'b1; start = 1'b1; dir = 1'b0; clear = 1'b0;
        load = 1'b0; load_idx = 3'd0; auto_en = 1'b0;
        tick(); tick();

        // Reset state, start held high across release
        chk("rst_oh", 32'(w_oh), 32'h1);
        chk("rst_idx", 32'(w_idx), 32'h0);
        chk("rst_first", 32'(w_first), 32'h1);
        chk("rst_last", 32'(w_last), 32'h0);
        chk("rst_pulse", 32'(w_pulse), 32'h0);
        chk("rst_err", 32'(w_err), 32'h0);
        reset = 1'b0;
        tick();
        chk("hold_start_oh", 32'(w_oh), 32'h1);
        chk("hold_start_pulse", 32'(w_pulse), 32'h0);
        tick();
        chk("hold_start_oh2", 32'(w_oh), 32'h1);
        start = 1'b0; tick();
        start = 1'b1; tick();
        chk("first_step_oh", 32'(w_oh), 32'h2);
        chk("first_step_idx", 32'(w_idx), 32'h1);
        chk("first_step_pulse", 32'(w_pulse), 32'h1);
        chk("first_step_f", 32'(f_oh), 32'h02);
        tick();
        chk("held_no_restep", 32'(w_oh), 32'h2);
        chk("pulse_one_cycle", 32'(w_pulse), 32'h0);
        start = 1'b0;

        // Four forward steps: wrap vs saturate vs 5 states
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clear_oh", 32'(w_oh), 32'h1);
        chk("clear_pulse", 32'(w_pulse), 32'h0);
        for (int i = 0; i < 4; i++) begin
            start = 1'b1; tick();
            chk($sformatf("fwd%0d_w_oh", i), 32'(w_oh), 32'(exp_w[i]));
            chk($sformatf("fwd%0d_w_pulse", i), 32'(w_pulse), 32'h1);
            chk($sformatf("fwd%0d_s_oh", i), 32'(s_oh), 32'(exp_s[i]));
            chk($sformatf("fwd%0d_s_pulse", i), 32'(s_pulse), 32'(exp_sp[i]));
            chk($sformatf("fwd%0d_f_oh", i), 32'(f_oh), 32'(exp_f[i]));
            start = 1'b0; tick();
        end
        chk("sat_at_last", 32'(s_last), 32'h1);
        chk("f_at_last", 32'(f_last), 32'h1);
        chk("f_idx4", 32'(f_idx), 32'h4);

        // Backward from S0
        clear = 1'b1; tick(); clear = 1'b0;
        dir = 1'b1; start = 1'b1; tick();
        chk("bwd_w_oh", 32'(w_oh), 32'h8);
        chk("bwd_w_pulse", 32'(w_pulse), 32'h1);
        chk("bwd_s_oh", 32'(s_oh), 32'h1);
        chk("bwd_s_pulse", 32'(s_pulse), 32'h0);
        chk("bwd_s_first", 32'(s_first), 32'h1);
        chk("bwd_f_oh", 32'(f_oh), 32'h10);
        start = 1'b0; tick();
        start = 1'b1; tick();
        chk("bwd2_w_oh", 32'(w_oh), 32'h4);
        chk("bwd2_f_oh", 32'(f_oh), 32'h08);
        start = 1'b0; dir = 1'b0; tick();

        // Indexed load, then clear+load+start together
        load = 1'b1; load_idx = 3'd2; tick(); load = 1'b0;
        chk("load2_w_oh", 32'(w_oh), 32'h4);
        chk("load2_w_idx", 32'(w_idx), 32'h2);
        chk("load2_w_pulse", 32'(w_pulse), 32'h0);
        chk("load2_s_oh", 32'(s_oh), 32'h4);
        chk("load2_f_oh", 32'(f_oh), 32'h04);
        clear = 1'b1; load = 1'b1; load_idx = 3'd3; start = 1'b1; tick();
        chk("clr_prio_oh", 32'(w_oh), 32'h1);
        chk("clr_prio_pulse", 32'(w_pulse), 32'h0);
        clear = 1'b0; load = 1'b0; tick();
        chk("edge_consumed_oh", 32'(w_oh), 32'h1);
        chk("edge_consumed_pulse", 32'(w_pulse), 32'h0);
        start = 1'b0;

        // Out-of-range load on the 5-state instance (4-state ones see index 2)
        load = 1'b1; load_idx = 3'd6; tick(); load = 1'b0;
        chk("ld6_f_oh", 32'(f_oh), 32'h01);
        chk("ld6_f_err", 32'(f_err), 32'h1);
        chk("ld6_f_pulse", 32'(f_pulse), 32'h0);
        chk("ld6_w_oh", 32'(w_oh), 32'h4);
        chk("ld6_w_err", 32'(w_err), 32'h0);
        tick();
        chk("ld6_err_one_cycle", 32'(f_err), 32'h0);
        load = 1'b1; load_idx = 3'd4; tick(); load = 1'b0;
        chk("ld4_f_oh", 32'(f_oh), 32'h10);
        chk("ld4_f_err", 32'(f_err), 32'h0);
        chk("ld4_w_oh", 32'(w_oh), 32'h1);

        // Async reset mid-cycle while at S3 with step_pulse high
        load = 1'b1; load_idx = 3'd2; tick(); load = 1'b0;
        start = 1'b1; tick();
        chk("pre_rst_oh", 32'(w_oh), 32'h8);
        chk("pre_rst_pulse", 32'(w_pulse), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_oh", 32'(w_oh), 32'h1);
        chk("async_rst_idx", 32'(w_idx), 32'h0);
        chk("async_rst_pulse", 32'(w_pulse), 32'h0);
        start = 1'b0;
        tick();
        reset = 1'b0;

        // Auto-stepping with DWELL=3
        auto_en = 1'b1;
`ifdef OHSM_AUTOSTEP_EN
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("auto%0d_oh", k + 1), 32'(w_oh), 32'(auto_oh[k]));
            chk($sformatf("auto%0d_pulse", k + 1), 32'(w_pulse), 32'(auto_p[k]));
            if (k == 5) start = 1'b1;
            if (k == 6) start = 1'b0;
        end
`else
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("noauto%0d_oh", k + 1), 32'(w_oh), 32'h1);
            chk($sformatf("noauto%0d_pulse", k + 1), 32'(w_pulse), 32'h0);
        end
`endif
        auto_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
